sequenciador_mult: RTL and testbench
====================================

# sequenciador_mult

Sequential controller for the shift-and-add multiplier datapath built from registers X, Y and Z and the add/sub ULA. On each multiplication request it steps the datapath through a fixed schedule: load the multiplier into X, load the multiplicand into Y, clear Z, then one test/accumulate/shift iteration per multiplier bit. Every cycle it drives the register control codes (clear/load/hold/shift) and the ULA operation select, and signals completion with a one-cycle `done`. It sits between the top-level request logic and the X/Y/Z/ULA datapath.

## Interface
- `WIDTH`, default 4, operand width in bits (minimum 2); sets the iteration count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a running operation.
- `signed_op`  in  1  1 = two's-complement multiplier; latched when `start` is accepted.
- `mult_bit`  in  1  datapath bit X[`bit_idx`], the multiplier bit under test.
- `op_sel`  out  1  operand bus select: 0 = operand A (to X), 1 = operand B (to Y).
- `bit_idx`  out  clog2(WIDTH)  index of the multiplier bit under test.
- `auxX`  out  2  X control: 00 clear, 01 load, 10 hold.
- `auxY`  out  3  Y control: 000 clear, 001 load, 010 hold, 011 shift left, 100 shift right.
- `auxZ`  out  2  Z control: 00 clear, 01 load ULA result, 10 hold.
- `auxULA`  out  1  0 = add (Z+Y), 1 = subtract (Z−Y).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Moore FSM. Outputs decode from the state register, `bit_idx` and the latched `signed_op` only. `mult_bit` affects only the next-state choice.
- Unless a state lists otherwise, it drives auxX=10, auxY=010, auxZ=10, auxULA=0 and op_sel=0.
- IDLE: busy=0. start=1 and abort=0 → LOADX. Latch signed_op. Clear bit_idx.
- LOADX: auxX=01, auxY=000, auxZ=00, op_sel=0 → LOADY.
- LOADY: auxY=001, op_sel=1 → TEST.
- TEST: all registers hold. mult_bit=1 → ADD. mult_bit=0 → SHIFT.
- ADD: auxZ=01. auxULA=1 only when the latched signed_op=1 and bit_idx=WIDTH−1 (negative weight of the sign bit); otherwise auxULA=0. Next state SHIFT.
- SHIFT: auxY=011 (multiplicand ×2).
  - bit_idx=WIDTH−1 → DONE.
  - Otherwise bit_idx+1 → TEST.
- DONE: done=1, busy=1 → IDLE. Z holds the product from this cycle until the next LOADX.
- Product width is 2·WIDTH and is held in Z. Sizing Y and Z to 2·WIDTH bits is the datapath's responsibility.
- `bit_idx` never wraps: it stops at WIDTH−1 and is cleared only in IDLE, on abort, or on reset.

## Timing
- Reset (asynchronous, immediate): state=IDLE, auxX=10, auxY=010, auxZ=10, auxULA=0, op_sel=0, bit_idx=0, busy=0, done=0, latched signed_op=0.
- Count cycle 1 as the cycle after the edge that accepts `start`.
  - Cycle 1: LOADX. Cycle 2: LOADY.
  - Each bit then takes 2 cycles (TEST, SHIFT), or 3 if mult_bit=1 (TEST, ADD, SHIFT).
  - `done` is high in cycle 3 + 2·WIDTH + k, where k = number of ones in the multiplier.
- Back-to-back: `start` can be accepted in the cycle after DONE, giving a minimum gap of 1 idle cycle.
- `start` during busy is ignored; it is not queued.
- `abort`=1 in any busy state except DONE → IDLE on the next edge. That forces done=0 and bit_idx=0; Z contents are undefined. Abort during DONE has no effect.
- `abort` and `start` together in IDLE: abort wins and start is ignored.
- Reset asserted mid-operation: outputs take their reset values immediately, with no done pulse.

## Test plan
- Reset: hold rst_n=0 mid-SHIFT (WIDTH=4) → all outputs at reset values within the same cycle. After release, the block stays in IDLE until start.
- Unsigned, multiplier 1011, multiplicand 0110: ADD visited at bit_idx 0, 1 and 3 with auxULA=0; done=1 in cycle 14; Z=66 during DONE.
- Multiplier 0000: no ADD state, auxZ never 01 after LOADX, done=1 in cycle 11, Z=0.
- signed_op=1, multiplier 1000 (−8), multiplicand 0011: the only ADD is at bit_idx=3 with auxULA=1; done in cycle 12; Z=−24 (8-bit 0xE8).
- start held high for 30 cycles: exactly two operations (second accepted the cycle after DONE) and two one-cycle done pulses; start ignored while busy.
- abort in TEST at bit_idx=2 → IDLE next cycle, busy=0, done never pulses. abort+start together in IDLE → stays IDLE.

Source files
------------

// File: rtl/sequenciador_mult_if.sv
// Request/control bundle between the top-level request logic, the X/Y/Z/ULA
// datapath and the shift-and-add multiplier sequencer.
interface sequenciador_mult_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(WIDTH);

    logic          start;
    logic          abort;
    logic          signed_op;
    logic          mult_bit;
    logic          op_sel;
    logic [IW-1:0] bit_idx;
    logic [1:0]    auxX;
    logic [2:0]    auxY;
    logic [1:0]    auxZ;
    logic          auxULA;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, signed_op, mult_bit,
        input  op_sel, bit_idx, auxX, auxY, auxZ, auxULA, busy, done
    );

    modport slave (
        input  start, abort, signed_op, mult_bit,
        output op_sel, bit_idx, auxX, auxY, auxZ, auxULA, busy, done
    );
endinterface

// File: rtl/sequenciador_mult.sv
// Moore sequencer stepping the X/Y/Z/ULA datapath through a shift-and-add
// multiplication; outputs are registered alongside the state they belong to.
//
// state   | meaning
// IDLE    | waiting for start, bit_idx cleared
// LOADX   | multiplier into X, clear Y and Z
// LOADY   | multiplicand into Y
// TEST    | all hold, inspect X[bit_idx]
// ADD     | Z <= Z +/- Y (subtract for signed sign bit)
// SHIFT   | Y <<= 1, advance bit_idx or finish
// DONE    | one-cycle done pulse, product valid in Z
module sequenciador_mult #(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    sequenciador_mult_if.slave  bus
);
    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [1:0] X_CLR = 2'b00, X_LOAD = 2'b01, X_HOLD = 2'b10;
    localparam logic [2:0] Y_CLR = 3'b000, Y_LOAD = 3'b001, Y_HOLD = 3'b010, Y_SHL = 3'b011;
    localparam logic [1:0] Z_CLR = 2'b00, Z_LOAD = 2'b01, Z_HOLD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOADX, S_LOADY, S_TEST, S_ADD, S_SHIFT, S_DONE
    } state_t;

    state_t        state;
    logic          signed_q;
    logic [IW-1:0] idx_q;
    logic [1:0]    auxx_q;
    logic [2:0]    auxy_q;
    logic [1:0]    auxz_q;
    logic          ula_q;
    logic          op_sel_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            signed_q <= 1'b0;
            idx_q    <= '0;
            auxx_q   <= X_HOLD;
            auxy_q   <= Y_HOLD;
            auxz_q   <= Z_HOLD;
            ula_q    <= 1'b0;
            op_sel_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Defaults describe the state being entered; branches override.
            auxx_q   <= X_HOLD;
            auxy_q   <= Y_HOLD;
            auxz_q   <= Z_HOLD;
            ula_q    <= 1'b0;
            op_sel_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    idx_q <= '0;
                    if (bus.start && !bus.abort) begin
                        state    <= S_LOADX;
                        signed_q <= bus.signed_op;
                        auxx_q   <= X_LOAD;
                        auxy_q   <= Y_CLR;
                        auxz_q   <= Z_CLR;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOADX: begin
                    state    <= S_LOADY;
                    auxy_q   <= Y_LOAD;
                    op_sel_q <= 1'b1;
                end
                S_LOADY: state <= S_TEST;
                S_TEST: begin
                    if (bus.mult_bit) begin
                        state  <= S_ADD;
                        auxz_q <= Z_LOAD;
                        // Sign bit of a two's-complement multiplier has negative weight.
                        ula_q  <= signed_q && (idx_q == LAST);
                    end else begin
                        state  <= S_SHIFT;
                        auxy_q <= Y_SHL;
                    end
                end
                S_ADD: begin
                    state  <= S_SHIFT;
                    auxy_q <= Y_SHL;
                end
                S_SHIFT: begin
                    if (idx_q == LAST) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        state <= S_TEST;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // DONE is committed: abort only cancels the working states.
            if (bus.abort && state != S_IDLE && state != S_DONE) begin
                state    <= S_IDLE;
                idx_q    <= '0;
                auxx_q   <= X_HOLD;
                auxy_q   <= Y_HOLD;
                auxz_q   <= Z_HOLD;
                ula_q    <= 1'b0;
                op_sel_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end
        end
    end

    assign bus.op_sel  = op_sel_q;
    assign bus.bit_idx = idx_q;
    assign bus.auxX    = auxx_q;
    assign bus.auxY    = auxy_q;
    assign bus.auxZ    = auxz_q;
    assign bus.auxULA  = ula_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_sequenciador_mult.sv
// Directed bench for sequenciador_mult with a behavioural X/Y/Z/ULA datapath
// so products, schedule and cycle counts can be checked against hand values.
module tb_sequenciador_mult;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    sequenciador_mult_if #(.WIDTH(W)) ifc ();

    sequenciador_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    logic [3:0] opa, opb, bus_v, x_reg;
    logic [7:0] y_reg, z_reg;
    logic       sgn_dp;

    assign bus_v        = ifc.op_sel ? opb : opa;
    assign ifc.mult_bit = x_reg[ifc.bit_idx];

    always @(posedge clk) begin
        case (ifc.auxX)
            2'b00:   x_reg <= 4'h0;
            2'b01:   x_reg <= bus_v;
            default: x_reg <= x_reg;
        endcase
        case (ifc.auxY)
            3'b000:  y_reg <= 8'h00;
            3'b001:  y_reg <= sgn_dp ? {{4{bus_v[3]}}, bus_v} : {4'h0, bus_v};
            3'b011:  y_reg <= y_reg << 1;
            3'b100:  y_reg <= y_reg >> 1;
            default: y_reg <= y_reg;
        endcase
        case (ifc.auxZ)
            2'b00:   z_reg <= 8'h00;
            2'b01:   z_reg <= ifc.auxULA ? z_reg - y_reg : z_reg + y_reg;
            default: z_reg <= z_reg;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic sgn, input int exp_cyc, input logic [7:0] exp_z,
                          input logic [3:0] exp_add, input logic [3:0] exp_sub);
        int         done_cyc;
        logic [3:0] add_m, sub_m;
        opa = a; opb = b; sgn_dp = sgn;
        ifc.signed_op = sgn;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.signed_op = 1'b0;
        check({tag, ".loadx"}, {ifc.auxX, ifc.auxY, ifc.auxZ, ifc.busy}, {2'b01, 3'b000, 2'b00, 1'b1});
        add_m = '0; sub_m = '0; done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (ifc.auxZ == 2'b01) begin
                add_m[ifc.bit_idx] = 1'b1;
                if (ifc.auxULA) sub_m[ifc.bit_idx] = 1'b1;
            end
            if (ifc.done) begin
                done_cyc = c;
                check({tag, ".z"}, z_reg, exp_z);
                break;
            end
            tick();
        end
        check({tag, ".done_cyc"}, done_cyc, exp_cyc);
        check({tag, ".add_bits"}, add_m, exp_add);
        check({tag, ".sub_bits"}, sub_m, exp_sub);
        tick();
        check({tag, ".after"}, {ifc.done, ifc.busy}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int   loads, dones, found, bad;
        logic reset_val_vec;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.signed_op = 1'b0;
        opa = '0; opb = '0; sgn_dp = 1'b0;
        #12;
        check("reset_vals", {ifc.busy, ifc.done, ifc.op_sel, ifc.auxULA, ifc.auxX, ifc.auxY, ifc.auxZ, ifc.bit_idx},
              {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b010, 2'b10, 2'b00});
        #10 rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_reset", {ifc.busy, ifc.auxX}, {1'b0, 2'b10});

        run_op("u1011x0110", 4'b1011, 4'b0110, 1'b0, 14, 8'd66, 4'b1011, 4'b0000);
        run_op("u0000", 4'b0000, 4'b0110, 1'b0, 11, 8'd0, 4'b0000, 4'b0000);
        run_op("s1000x0011", 4'b1000, 4'b0011, 1'b1, 12, 8'hE8, 4'b1000, 4'b1000);
        run_op("s1111x1111", 4'b1111, 4'b1111, 1'b1, 15, 8'h01, 4'b1111, 4'b1000);

        // start held for 30 sampling edges: accepted at edge 0 and after the first DONE
        opa = 4'b1011; opb = 4'b0001; sgn_dp = 1'b0;
        loads = 0; dones = 0; bad = 0;
        ifc.start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 30) ifc.start = 1'b0;
            if (ifc.auxX == 2'b01) loads++;
            if (ifc.done) begin
                dones++;
                if (i != 14 && i != 29) bad++;
            end
        end
        check("hold_start.loads", loads, 2);
        check("hold_start.dones", dones, 2);
        check("hold_start.done_cycles", bad, 0);

        // abort in TEST at bit_idx 2
        opa = 4'b1011; opb = 4'b0110;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.busy && ifc.auxX == 2'b10 && ifc.auxY == 3'b010 && ifc.auxZ == 2'b10
                && !ifc.done && ifc.bit_idx == 2'd2) begin
                found = 1;
                break;
            end
            tick();
        end
        check("abort.found_test2", found, 1);
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0;
        check("abort.idle", {ifc.busy, ifc.done, ifc.bit_idx}, {1'b0, 1'b0, 2'b00});
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.done || ifc.busy) dones++;
        end
        check("abort.no_done", dones, 0);

        // abort and start together in IDLE
        ifc.start = 1'b1; ifc.abort = 1'b1;
        tick();
        ifc.start = 1'b0; ifc.abort = 1'b0;
        check("abort_start.idle", {ifc.busy, ifc.auxX}, {1'b0, 2'b10});

        // asynchronous reset in SHIFT with bit_idx 1
        opa = 4'b1111; opb = 4'b0011;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.auxY == 3'b011 && ifc.bit_idx == 2'd1) begin
                found = 1;
                break;
            end
            tick();
        end
        check("rst_mid.found_shift", found, 1);
        #2 rst_n = 1'b0;
        #1;
        reset_val_vec = ({ifc.busy, ifc.done, ifc.op_sel, ifc.auxULA, ifc.auxX, ifc.auxY, ifc.auxZ, ifc.bit_idx}
                         === {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b010, 2'b10, 2'b00});
        check("rst_mid.outputs", reset_val_vec, 1'b1);
        #14 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifc.busy || ifc.done || ifc.auxX == 2'b01) bad++;
        end
        check("rst_mid.stays_idle", bad, 0);

        run_op("post_rst", 4'b0101, 4'b0011, 1'b0, 13, 8'd15, 4'b0101, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
